// File: rtl/vec_lane_alu.sv
// vec_lane_alu: multi-cycle signed element-wise add/sub/mul, LPC lanes per beat.
// Define VEC_LANE_ALU_SAT_EN to clamp overflowing res_lo lanes instead of wrapping.
module vec_lane_alu #(
  parameter int WIDTH = 16,
  parameter int LANES = 32,
  parameter int LPC   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             op,
  input  logic [LANES*WIDTH-1:0] a_vec,
  input  logic [LANES*WIDTH-1:0] b_vec,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   ovf,
  output logic [LANES*WIDTH-1:0] res_lo,
  output logic [LANES*WIDTH-1:0] res_hi
);

  localparam int BEATS = LANES / LPC;
  localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int VW    = LANES * WIDTH;
  localparam int EW    = 2 * WIDTH;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state, state_nx;
  logic [KW-1:0]  k, k_nx;
  logic [VW-1:0]  a_q, b_q;
  logic [1:0]     op_q;
  logic           take, illegal, last;

  logic [WIDTH-1:0]     lo_b [LPC];
  logic [WIDTH-1:0]     hi_b [LPC];
  logic [LPC-1:0]       ovf_b;
  logic [WIDTH-1:0]     aw, bw;
  logic signed [EW-1:0] ea, eb, ev;
  int                   idx;

  assign busy = (state == RUN);

  // State and beat counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
    end else begin
      state <= state_nx;
      k     <= k_nx;
    end
  end

  // Next state: accept legal starts in IDLE, leave RUN after the last beat
  always_comb begin
    take     = (state == IDLE) && start && (op != 2'b11);
    illegal  = (state == IDLE) && start && (op == 2'b11);
    last     = (state == RUN) && (k == KW'(BEATS - 1));
    state_nx = state;
    k_nx     = k;
    unique case (state)
      IDLE: begin
        if (take) begin
          state_nx = RUN;
          k_nx     = '0;
        end
      end
      RUN: begin
        if (last) begin
          state_nx = IDLE;
          k_nx     = '0;
        end else begin
          k_nx = k + 1'b1;
        end
      end
    endcase
  end

  // Exact 2W-bit result, overflow flag and low-half selection per beat lane
  always_comb begin
    ovf_b = '0;
    aw    = '0;
    bw    = '0;
    ea    = '0;
    eb    = '0;
    ev    = '0;
    idx   = 0;
    for (int j = 0; j < LPC; j++) begin
      idx = int'(k) * LPC + j;
      aw  = a_q[idx*WIDTH +: WIDTH];
      bw  = b_q[idx*WIDTH +: WIDTH];
      ea  = {{WIDTH{aw[WIDTH-1]}}, aw};
      eb  = {{WIDTH{bw[WIDTH-1]}}, bw};
      unique case (op_q)
        2'b00:   ev = ea + eb;
        2'b01:   ev = ea - eb;
        default: ev = ea * eb;
      endcase
      ovf_b[j] = ~(&ev[EW-1:WIDTH-1] | ~|ev[EW-1:WIDTH-1]);
      hi_b[j]  = ev[EW-1:WIDTH];
      lo_b[j]  = ev[WIDTH-1:0];
`ifdef VEC_LANE_ALU_SAT_EN
      if (ovf_b[j]) begin
        lo_b[j] = ev[EW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                           : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
    end
  end

  // Operand capture, lane write-back and completion flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      res_lo <= '0;
      res_hi <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (take) begin
        a_q  <= a_vec;
        b_q  <= b_vec;
        op_q <= op;
        ovf  <= 1'b0;
        err  <= 1'b0;
      end
      if (illegal) begin
        done <= 1'b1;
        err  <= 1'b1;
      end
      if (busy) begin
        for (int j = 0; j < LPC; j++) begin
          res_lo[(int'(k)*LPC + j)*WIDTH +: WIDTH] <= lo_b[j];
          res_hi[(int'(k)*LPC + j)*WIDTH +: WIDTH] <= hi_b[j];
        end
        ovf <= ovf | (|ovf_b);
        if (last) begin
          done <= 1'b1;
          err  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vec_lane_alu.sv
// tb_vec_lane_alu: random and directed stimulus against a lane-array model.
// Honours VEC_LANE_ALU_SAT_EN the same way as the design.
module tb_vec_lane_alu;

  localparam int W     = 16;
  localparam int L     = 32;
  localparam int P     = 8;
  localparam int BEATS = L / P;
  localparam int VW    = L * W;
  localparam longint MAXV = (longint'(1) << (W - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (W - 1));

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [VW-1:0] a_vec = '0;
  logic [VW-1:0] b_vec = '0;
  logic          busy, done, err, ovf;
  logic [VW-1:0] res_lo, res_hi;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vec_lane_alu #(.WIDTH(W), .LANES(L), .LPC(P)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .a_vec(a_vec), .b_vec(b_vec),
    .busy(busy), .done(done), .err(err), .ovf(ovf),
    .res_lo(res_lo), .res_hi(res_hi)
  );

  task automatic chk(input string nm, input logic [VW-1:0] act,
                     input logic [VW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic                m_busy, m_done, m_err, m_ovf;
  logic [W-1:0]        m_lo [L];
  logic [W-1:0]        m_hi [L];
  logic signed [W-1:0] ca [L];
  logic signed [W-1:0] cb [L];
  logic [1:0]          cop;
  int                  beat;
  int                  li;
  longint              le;

  function automatic longint exact(input logic [1:0] o,
                                   input logic signed [W-1:0] x,
                                   input logic signed [W-1:0] y);
    longint ex = x;
    longint ey = y;
    case (o)
      2'd0:    return ex + ey;
      2'd1:    return ex - ey;
      default: return ex * ey;
    endcase
  endfunction

  function automatic logic [W-1:0] lo_of(input longint e);
    logic [63:0] u = e;
    bit o = (e > MAXV) || (e < MINV);
`ifdef VEC_LANE_ALU_SAT_EN
    if (o) return (e > 0) ? 16'h7FFF : 16'h8000;
`endif
    if (o) return u[W-1:0];
    return u[W-1:0];
  endfunction

  function automatic logic [W-1:0] hi_of(input longint e);
    logic [63:0] u = e;
    return u[2*W-1:W];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_err = 0; m_ovf = 0; beat = 0;
      for (int i = 0; i < L; i++) begin
        m_lo[i] = '0;
        m_hi[i] = '0;
      end
    end else begin
      m_done = 0;
      if (m_busy) begin
        for (int j = 0; j < P; j++) begin
          li = beat * P + j;
          le = exact(cop, ca[li], cb[li]);
          m_lo[li] = lo_of(le);
          m_hi[li] = hi_of(le);
          if (le > MAXV || le < MINV) m_ovf = 1;
        end
        beat++;
        if (beat == BEATS) begin
          m_busy = 0; m_done = 1; m_err = 0;
        end
      end else if (start) begin
        if (op == 2'b11) begin
          m_done = 1; m_err = 1;
        end else begin
          for (int i = 0; i < L; i++) begin
            ca[i] = a_vec[i*W +: W];
            cb[i] = b_vec[i*W +: W];
          end
          cop = op; m_busy = 1; beat = 0; m_ovf = 0;
        end
      end
    end
  end

  function automatic logic [VW-1:0] pack_lo();
    logic [VW-1:0] v;
    for (int i = 0; i < L; i++) v[i*W +: W] = m_lo[i];
    return v;
  endfunction

  function automatic logic [VW-1:0] pack_hi();
    logic [VW-1:0] v;
    for (int i = 0; i < L; i++) v[i*W +: W] = m_hi[i];
    return v;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", VW'(busy), VW'(m_busy));
      chk("done", VW'(done), VW'(m_done));
      if (m_done) chk("err", VW'(err), VW'(m_err));
      if (m_done && !m_err) chk("ovf", VW'(ovf), VW'(m_ovf));
      chk("res_lo", res_lo, pack_lo());
      chk("res_hi", res_hi, pack_hi());
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [W-1:0] rand_lane();
    logic [W-1:0] v;
    case ($urandom % 4)
      0:       v = ($urandom % 2) ? 16'h8000 : 16'h7FFF;
      1:       v = W'($urandom_range(0, 600)) - 16'd300;
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < L; i++) v[i*W +: W] = rand_lane();
    return v;
  endfunction

  task automatic fill(input logic [W-1:0] av, input logic [W-1:0] bv);
    for (int i = 0; i < L; i++) begin
      a_vec[i*W +: W] = av;
      b_vec[i*W +: W] = bv;
    end
  endtask

  // Launch at a negedge; return at the negedge where done is seen.
  task automatic run(input logic [1:0] o, input bit scr, output int n);
    op = o;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 3 * BEATS + 4) begin
      if (scr) begin
        a_vec = rand_vec();
        b_vec = rand_vec();
        op    = 2'($urandom);
        start = 1'($urandom);
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (!done) chk("done_timeout", VW'(done), VW'(1));
  endtask

  logic [VW-1:0] saved;
  int            n;
  logic [1:0]    ro;

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", VW'(busy), '0);
    chk("rst_done", VW'(done), '0);
    chk("rst_err", VW'(err), '0);
    chk("rst_ovf", VW'(ovf), '0);
    chk("rst_lo", res_lo, '0);
    chk("rst_hi", res_hi, '0);
    @(negedge clk);

    for (int i = 0; i < L; i++) begin
      a_vec[i*W +: W] = W'(i);
      b_vec[i*W +: W] = W'(2 * i);
    end
    run(2'b00, 1'b0, n);
    chk("lat_add", VW'(n), VW'(BEATS + 1));
    chk("add_lo5", VW'(res_lo[5*W +: W]), VW'(15));
    chk("add_lo31", VW'(res_lo[31*W +: W]), VW'(93));
    chk("add_hi", res_hi, '0);
    chk("add_ovf", VW'(ovf), '0);
    chk("add_err", VW'(err), '0);
    chk("mdl_add_lo5", VW'(m_lo[5]), VW'(15));

    fill(16'd5, 16'd7);
    run(2'b01, 1'b0, n);
    chk("sub_lo0", VW'(res_lo[0 +: W]), VW'(16'hFFFE));
    chk("sub_hi9", VW'(res_hi[9*W +: W]), VW'(16'hFFFF));
    chk("sub_ovf", VW'(ovf), '0);
    chk("mdl_sub_hi", VW'(m_hi[3]), VW'(16'hFFFF));

    fill(16'd300, 16'd300);
    run(2'b10, 1'b0, n);
    chk("mul_hi", VW'(res_hi[4*W +: W]), VW'(16'h0001));
    chk("mul_ovf", VW'(ovf), VW'(1));
`ifdef VEC_LANE_ALU_SAT_EN
    chk("mul_lo", VW'(res_lo[4*W +: W]), VW'(16'h7FFF));
    chk("mdl_mul_lo", VW'(m_lo[4]), VW'(16'h7FFF));
`else
    chk("mul_lo", VW'(res_lo[4*W +: W]), VW'(16'h5F90));
    chk("mdl_mul_lo", VW'(m_lo[4]), VW'(16'h5F90));
`endif

    fill(16'h8000, 16'h8000);
    run(2'b10, 1'b0, n);
    chk("mulmin_hi", VW'(res_hi[30*W +: W]), VW'(16'h4000));
    chk("mulmin_ovf", VW'(ovf), VW'(1));
    chk("mdl_mulmin_hi", VW'(m_hi[30]), VW'(16'h4000));

    a_vec = rand_vec();
    b_vec = rand_vec();
    run(2'b10, 1'b1, n);
    chk("lat_scr", VW'(n), VW'(BEATS + 1));
    a_vec = rand_vec();
    b_vec = rand_vec();
    run(2'b00, 1'b1, n);
    chk("lat_b2b", VW'(n), VW'(BEATS + 1));

    saved = res_lo;
    run(2'b11, 1'b0, n);
    chk("ill_lat", VW'(n), VW'(1));
    chk("ill_err", VW'(err), VW'(1));
    chk("ill_busy", VW'(busy), '0);
    chk("ill_res", res_lo, saved);
    @(negedge clk);
    chk("ill_busy2", VW'(busy), '0);

    a_vec = rand_vec();
    b_vec = rand_vec();
    op = 2'b10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", VW'(busy), '0);
    chk("arst_done", VW'(done), '0);
    chk("arst_ovf", VW'(ovf), '0);
    chk("arst_lo", res_lo, '0);
    chk("arst_hi", res_hi, '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("no_done", VW'(done), '0);
    end
    for (int i = 0; i < L; i++) begin
      a_vec[i*W +: W] = W'(i);
      b_vec[i*W +: W] = W'(2 * i);
    end
    run(2'b00, 1'b0, n);
    chk("lat_after_rst", VW'(n), VW'(BEATS + 1));
    chk("post_rst_lo7", VW'(res_lo[7*W +: W]), VW'(21));

    for (int t = 0; t < 40; t++) begin
      a_vec = rand_vec();
      b_vec = rand_vec();
      ro = ($urandom % 8 == 0) ? 2'b11 : 2'($urandom % 3);
      run(ro, 1'($urandom), n);
      chk("lat_rand", VW'(n), (ro == 2'b11) ? VW'(1) : VW'(BEATS + 1));
      if ($urandom % 3 == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
